// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: FSM states, ERET code and stall patterns for the pipeline sequencer
package pipe_ctrl_pkg;
   typedef enum logic [1:0] {RUN = 2'b00, EXC_HOLD = 2'b01, FLUSH = 2'b10} state_e;
   localparam logic [31:0] ERET_EXC = 32'h0000_000e;
   localparam logic STOP = 1'b1;
   localparam logic NO_STOP = 1'b0;
   localparam logic [5:0] STALL_NONE = {6{NO_STOP}};
   localparam logic [5:0] STALL_ID = 6'b000111;
   localparam logic [5:0] STALL_EX = 6'b001111;
   localparam logic [5:0] STALL_MEM = 6'b011111;
   localparam logic [5:0] STALL_ALL = {6{STOP}};
endpackage

// File: rtl/pipe_ctrl_wdog.sv
// pipe_ctrl_wdog: saturating MEM-stall watchdog that fires on the MEM_TIMEOUT-th consecutive stall cycle
module pipe_ctrl_wdog #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic req,
   input  logic exc,
   output logic fire
);
   localparam int W = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);
   localparam logic [W-1:0] MAX = '1;
   logic [W-1:0] cnt_q, cnt_d;
   always_comb begin
      fire = run && req && !exc && cnt_q == LAST;
      cnt_d = (run && req && !exc && !fire) ? (cnt_q == MAX ? cnt_q : cnt_q + 1'b1) : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall merge, exception/ERET flush sequencer and bus watchdog; PIPE_CTRL_PERF_EN adds stall/flush counters
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
   parameter int MEM_TIMEOUT = 16,
   parameter logic [31:0] TO_EXCCODE = 32'h0000_000f
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_from_id,
   input  logic        stallreq_from_ex,
   input  logic        stallreq_from_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        timeout_exc,
   output logic [31:0] excepttype_o,
`ifdef PIPE_CTRL_PERF_EN
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt,
`endif
   output logic        busy
);
   state_e state_q, state_d;
   logic [31:0] exc_type_q, exc_type_d, target_q, target_d, new_pc_q, new_pc_d;
   logic run, exc, trap;
   assign run = state_q == RUN;
   assign exc = excepttype_i != '0;
   assign trap = run && (exc || timeout_exc);
   pipe_ctrl_wdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
      .clk(clk), .rst(rst), .run(run), .req(stallreq_from_mem), .exc(exc), .fire(timeout_exc)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         exc_type_q <= '0;
         target_q <= '0;
         new_pc_q <= '0;
      end else begin
         state_q <= state_d;
         exc_type_q <= exc_type_d;
         target_q <= target_d;
         new_pc_q <= new_pc_d;
      end
   end
   always_comb begin
      state_d = run ? (trap ? EXC_HOLD : RUN) : state_q == EXC_HOLD ? FLUSH : RUN;
      exc_type_d = trap ? (exc ? excepttype_i : TO_EXCCODE) : exc_type_q;
      target_d = trap ? ((exc && excepttype_i == ERET_EXC) ? cp0_epc_i : EXC_VECTOR) : target_q;
      new_pc_d = state_q == EXC_HOLD ? target_q : new_pc_q;
   end
   always_comb begin
      busy = !run;
      flush = state_q == FLUSH;
      new_pc = new_pc_q;
      excepttype_o = state_q == EXC_HOLD ? exc_type_q : timeout_exc ? TO_EXCCODE : '0;
      stall = (trap || state_q == EXC_HOLD) ? STALL_ALL :
              !run              ? STALL_NONE :
              stallreq_from_mem ? STALL_MEM :
              stallreq_from_ex  ? STALL_EX :
              stallreq_from_id  ? STALL_ID : STALL_NONE;
   end
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;
   always_comb begin
      perf_stall_d = perf_stall_q + {31'b0, |stall};
      perf_flush_d = perf_flush_q + {31'b0, flush};
      perf_stall_cnt = perf_stall_q;
      perf_flush_cnt = perf_flush_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
      end
   end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: vector table, directed corner sequences and random run against a cycle-level reference model
module tb_pipe_ctrl;
   logic clk = 1'b0, rst = 1'b1;
   logic id_r = 1'b0, ex_r = 1'b0, mem_r = 1'b0;
   logic [31:0] et = '0, epc = '0;
   logic [5:0] stall;
   logic flush, timeout_exc, busy;
   logic [31:0] new_pc, excepttype_o;
   int n_chk = 0, n_pass = 0;
   typedef struct {
      logic id, ex, mem;
      logic [5:0] st;
   } vec_t;
   vec_t tbl[8];
   pipe_ctrl dut (
      .clk(clk), .rst(rst), .stallreq_from_id(id_r), .stallreq_from_ex(ex_r),
      .stallreq_from_mem(mem_r), .excepttype_i(et), .cp0_epc_i(epc), .stall(stall),
      .flush(flush), .new_pc(new_pc), .timeout_exc(timeout_exc),
      .excepttype_o(excepttype_o), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask
   task automatic drive(input logic i, input logic e, input logic m, input logic [31:0] t, input logic [31:0] p);
      @(posedge clk);
      #1;
      id_r = i; ex_r = e; mem_r = m; et = t; epc = p;
      @(negedge clk);
   endtask
   task automatic idle();
      drive(0, 0, 0, 0, 0);
   endtask
   initial begin
      int hold, mem_run;
      logic [31:0] cap_type, cap_tgt, last_pc, x_eto;
      logic [5:0] x_st;
      logic x_fl, x_bz, x_to, tr;
      tbl[0] = '{1, 1, 0, 6'b001111};
      tbl[1] = '{1, 1, 1, 6'b011111};
      tbl[2] = '{0, 0, 0, 6'b000000};
      tbl[3] = '{1, 0, 0, 6'b000111};
      tbl[4] = '{0, 1, 0, 6'b001111};
      tbl[5] = '{0, 0, 1, 6'b011111};
      tbl[6] = '{1, 0, 1, 6'b011111};
      tbl[7] = '{0, 1, 1, 6'b011111};
      idle();
      idle();
      chk("rst_stall", 32'(stall), 0);
      chk("rst_flush", 32'(flush), 0);
      chk("rst_new_pc", new_pc, 0);
      chk("rst_timeout", 32'(timeout_exc), 0);
      chk("rst_exc_o", excepttype_o, 0);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].id, tbl[i].ex, tbl[i].mem, 0, 0);
         chk($sformatf("prio_%0d", i), 32'(stall), 32'(tbl[i].st));
      end
      idle();
      drive(0, 0, 0, 32'h8, 0);
      chk("exc_c0_stall", 32'(stall), 32'h3f);
      idle();
      chk("exc_c1_stall", 32'(stall), 32'h3f);
      chk("exc_c1_type", excepttype_o, 32'h8);
      chk("exc_c1_busy", 32'(busy), 1);
      idle();
      chk("exc_c2_flush", 32'(flush), 1);
      chk("exc_c2_pc", new_pc, 32'h20);
      chk("exc_c2_stall", 32'(stall), 0);
      idle();
      chk("exc_c3_flush", 32'(flush), 0);
      chk("exc_c3_busy", 32'(busy), 0);
      chk("exc_c3_pc_hold", new_pc, 32'h20);
      drive(0, 0, 0, 32'he, 32'h1234);
      idle();
      chk("eret_hold_pc", new_pc, 32'h20);
      idle();
      chk("eret_flush", 32'(flush), 1);
      chk("eret_pc", new_pc, 32'h1234);
      idle();
      for (int i = 1; i <= 15; i++) begin
         drive(0, 0, 1, 0, 0);
         chk($sformatf("wd15_to_%0d", i), 32'(timeout_exc), 0);
      end
      idle();
      chk("wd15_busy", 32'(busy), 0);
      for (int i = 1; i <= 16; i++) begin
         drive(0, 0, 1, 0, 0);
         chk($sformatf("wd16_to_%0d", i), 32'(timeout_exc), 32'(i == 16));
      end
      idle();
      chk("wd16_type", excepttype_o, 32'hf);
      chk("wd16_hold_stall", 32'(stall), 32'h3f);
      idle();
      chk("wd16_flush", 32'(flush), 1);
      chk("wd16_pc", new_pc, 32'h20);
      idle();
      for (int i = 0; i < 10; i++) drive(0, 0, 1, 0, 0);
      drive(0, 0, 1, 32'h4, 0);
      chk("sim_stall", 32'(stall), 32'h3f);
      chk("sim_to", 32'(timeout_exc), 0);
      idle();
      chk("sim_type", excepttype_o, 32'h4);
      idle();
      chk("sim_flush", 32'(flush), 1);
      for (int i = 1; i <= 15; i++) begin
         drive(0, 0, 1, 0, 0);
         chk($sformatf("sim_cnt_clr_%0d", i), 32'(timeout_exc), 0);
      end
      idle();
      drive(0, 0, 0, 32'h8, 0);
      idle();
      rst = 1'b1;
      idle();
      chk("rmid_flush", 32'(flush), 0);
      chk("rmid_stall", 32'(stall), 0);
      chk("rmid_busy", 32'(busy), 0);
      chk("rmid_pc", new_pc, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         idle();
         chk($sformatf("rmid_noflush_%0d", i), 32'(flush), 0);
      end
      hold = 0; mem_run = 0; cap_type = 0; cap_tgt = 0; last_pc = 0;
      for (int c = 0; c < 2000; c++) begin
         if (hold != 0) idle();
         else drive($urandom % 4 == 0, $urandom % 4 == 0, $urandom % 100 < 92,
                    ($urandom % 40 == 0) ? (($urandom % 3 == 0) ? 32'he : 32'($urandom_range(1, 31))) : 32'h0,
                    $urandom);
         x_to = 0; x_eto = 0; x_fl = 0; x_bz = hold != 0; x_st = 0; tr = 0;
         if (hold == 0) begin
            x_to = et == 0 && mem_r && mem_run == 15;
            tr = et != 0 || x_to;
            x_eto = x_to ? 32'hf : 32'h0;
            x_st = tr ? 6'h3f : mem_r ? 6'h1f : ex_r ? 6'h0f : id_r ? 6'h07 : 6'h00;
         end else if (hold == 2) begin
            x_st = 6'h3f;
            x_eto = cap_type;
         end else x_fl = 1;
         chk("rnd_stall", 32'(stall), 32'(x_st));
         chk("rnd_flush", 32'(flush), 32'(x_fl));
         chk("rnd_busy", 32'(busy), 32'(x_bz));
         chk("rnd_to", 32'(timeout_exc), 32'(x_to));
         chk("rnd_exc_o", excepttype_o, x_eto);
         chk("rnd_pc", new_pc, hold == 1 ? cap_tgt : last_pc);
         if (hold == 0) begin
            if (tr) begin
               cap_type = x_to ? 32'hf : et;
               cap_tgt = et == 32'he ? epc : 32'h20;
               hold = 2;
               mem_run = 0;
            end else mem_run = mem_r ? mem_run + 1 : 0;
         end else if (hold == 2) hold = 1;
         else begin
            last_pc = cap_tgt;
            hold = 0;
         end
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
